// File: rtl/min_width_shaper.sv
// Reshapes a 1-bit signal so every output level lasts at least MIN_WIDTH clks;
// short input pulses are queued and replayed. Optional macro: MIN_WIDTH_SHAPER_STRETCH_CNT_EN.
module min_width_shaper #(
  parameter int MIN_WIDTH   = 4,
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inData,
  input  logic        clearOverflow,
  output logic        outData,
  output logic        busy,
  output logic        overflow
`ifdef MIN_WIDTH_SHAPER_STRETCH_CNT_EN
  ,
  output logic [15:0] stretchCount
`endif
);

  localparam int MW = (MIN_WIDTH < 1) ? 1 : MIN_WIDTH;
  localparam int MP = (MAX_PENDING < 1) ? 1 : MAX_PENDING;
  localparam int HW = (MW <= 1) ? 1 : $clog2(MW);
  localparam int PW = $clog2(MP + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DRAIN
  } phase_t;

  logic          lastIn;
  logic [HW-1:0] holdCnt;
  logic [PW-1:0] pendCnt;
  logic [PW-1:0] pendNext;
  logic          inEdge;
  logic          toggle;
  logic          merge;
  phase_t        phase;

  assign inEdge = inData ^ lastIn;

  always_comb begin
    phase = IDLE;
    if (holdCnt != '0)      phase = HOLD;
    else if (pendCnt != '0) phase = DRAIN;
  end

  // A queued edge always fires once the hold expires; a fresh edge fires only from idle.
  assign toggle = (phase == DRAIN) || ((phase == IDLE) && inEdge);
  assign merge  = (pendCnt == PW'(MP)) && inEdge && !toggle;

  always_comb begin
    pendNext = pendCnt;
    if (merge)                pendNext = PW'(MP - 1);
    else if (inEdge && !toggle) pendNext = pendCnt + PW'(1);
    else if (!inEdge && toggle) pendNext = pendCnt - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastIn   <= 1'b0;
      outData  <= 1'b0;
      holdCnt  <= '0;
      pendCnt  <= '0;
      overflow <= 1'b0;
    end else begin
      lastIn  <= inData;
      pendCnt <= pendNext;
      if (toggle) begin
        outData <= ~outData;
        holdCnt <= HW'(MW - 1);
      end else if (holdCnt != '0) begin
        holdCnt <= holdCnt - HW'(1);
      end
      if (merge)              overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
    end
  end

  assign busy = (phase != IDLE);

`ifdef MIN_WIDTH_SHAPER_STRETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || clearOverflow) stretchCount <= '0;
    else if ((outData != lastIn) && (stretchCount != '1))
      stretchCount <= stretchCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_min_width_shaper.sv
// Scoreboard bench: three shaper instances with different parameters share stimulus;
// an edge-queue reference model predicts each output, a negedge monitor checks.
module tb_min_width_shaper;

  logic clk = 1'b0;
  logic rst, inData, clearOverflow;
  logic outD [3];
  logic busyD[3];
  logic ovD  [3];
`ifdef MIN_WIDTH_SHAPER_STRETCH_CNT_EN
  logic [15:0] scD[3];
`endif

  always #5 clk = ~clk;

  min_width_shaper #(.MIN_WIDTH(4), .MAX_PENDING(4)) dutA (
    .clk(clk), .rst(rst), .inData(inData), .clearOverflow(clearOverflow),
    .outData(outD[0]), .busy(busyD[0]), .overflow(ovD[0])
`ifdef MIN_WIDTH_SHAPER_STRETCH_CNT_EN
    , .stretchCount(scD[0])
`endif
  );
  min_width_shaper #(.MIN_WIDTH(4), .MAX_PENDING(2)) dutB (
    .clk(clk), .rst(rst), .inData(inData), .clearOverflow(clearOverflow),
    .outData(outD[1]), .busy(busyD[1]), .overflow(ovD[1])
`ifdef MIN_WIDTH_SHAPER_STRETCH_CNT_EN
    , .stretchCount(scD[1])
`endif
  );
  min_width_shaper #(.MIN_WIDTH(0), .MAX_PENDING(0)) dutC (
    .clk(clk), .rst(rst), .inData(inData), .clearOverflow(clearOverflow),
    .outData(outD[2]), .busy(busyD[2]), .overflow(ovD[2])
`ifdef MIN_WIDTH_SHAPER_STRETCH_CNT_EN
    , .stretchCount(scD[2])
`endif
  );

  // Effective parameters after clamping to at least 1
  int mw[3] = '{4, 4, 1};
  int mp[3] = '{4, 2, 1};

  typedef struct {
    logic o  [3];
    logic b  [3];
    logic ov [3];
    int   sc [3];
  } exp_t;

  exp_t sbq[$];
  int vectors    = 0;
  int miscompares = 0;
  int edgeIdx    = 0;

  // Model: output level, clk index of the last output change, count of queued edges.
  logic mOut[3], mLast[3], mOv[3];
  int   mLastT[3], mPend[3], mSc[3];

  task automatic modelStep(input int i, input logic x, input logic c, input logic r);
    logic ed, can, setOv;
    int e;
    e = edgeIdx;
    if (r) begin
      mOut[i] = 1'b0; mLast[i] = 1'b0; mOv[i] = 1'b0;
      mPend[i] = 0; mLastT[i] = -1000; mSc[i] = 0;
    end else begin
      ed    = (x != mLast[i]);
      can   = ((e - mLastT[i]) >= mw[i]);
      setOv = 1'b0;
      if (c) mSc[i] = 0;
      else if ((mOut[i] != mLast[i]) && (mSc[i] < 65535)) mSc[i]++;
      if (can && (mPend[i] > 0 || ed)) begin
        mOut[i]   = ~mOut[i];
        mLastT[i] = e;
        if (!ed) mPend[i]--;
      end else if (ed) begin
        if (mPend[i] == mp[i]) begin
          mPend[i] = mp[i] - 1;
          setOv    = 1'b1;
        end else begin
          mPend[i]++;
        end
      end
      if (setOv) mOv[i] = 1'b1;
      else if (c) mOv[i] = 1'b0;
      mLast[i] = x;
    end
  endtask

  function automatic logic modelBusy(input int i, input int e);
    return (mPend[i] > 0) || ((mw[i] - 1 - (e - mLastT[i])) > 0);
  endfunction

  task automatic step(input logic x, input logic c, input logic r);
    exp_t ex;
    inData = x; clearOverflow = c; rst = r;
    for (int i = 0; i < 3; i++) begin
      modelStep(i, x, c, r);
      ex.o[i]  = mOut[i];
      ex.b[i]  = modelBusy(i, edgeIdx);
      ex.ov[i] = mOv[i];
      ex.sc[i] = mSc[i];
    end
    sbq.push_back(ex);
    edgeIdx++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(inData, 1'b0, 1'b0);
  endtask

  // Monitor: every output sample after a clock edge is checked against the queue head
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        ex = sbq.pop_front();
        vectors++;
        for (int i = 0; i < 3; i++) begin
          if (outD[i] !== ex.o[i]) begin
            miscompares++;
            $display("FAIL outData[%0d] vec %0d: got %b want %b", i, vectors, outD[i], ex.o[i]);
          end
          if (busyD[i] !== ex.b[i]) begin
            miscompares++;
            $display("FAIL busy[%0d] vec %0d: got %b want %b", i, vectors, busyD[i], ex.b[i]);
          end
          if (ovD[i] !== ex.ov[i]) begin
            miscompares++;
            $display("FAIL overflow[%0d] vec %0d: got %b want %b", i, vectors, ovD[i], ex.ov[i]);
          end
`ifdef MIN_WIDTH_SHAPER_STRETCH_CNT_EN
          if (scD[i] !== 16'(ex.sc[i])) begin
            miscompares++;
            $display("FAIL stretchCount[%0d] vec %0d: got %0d want %0d", i, vectors, scD[i], ex.sc[i]);
          end
`endif
        end
      end
    end
  end

  initial begin
    logic x;
    int thr;
    // Reset with input low, then quiet
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
    idle(10);
    // Single 1-clk pulse
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    idle(12);
    // Long high level passes through unchanged in width
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    idle(20);
    // Two back-to-back 1-clk pulses
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    idle(30);
    // Toggle every clk: overflows the shallow queues, then clear
    for (int k = 0; k < 8; k++) step(~inData, 1'b0, 1'b0);
    idle(40);
    step(inData, 1'b1, 1'b0);
    idle(5);
    // Reset while holding with queued edges
    step(~inData, 1'b0, 1'b0);
    step(~inData, 1'b0, 1'b0);
    step(~inData, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(20);
    // Random traffic with varying edge density, occasional clears and resets
    for (int blk = 0; blk < 8; blk++) begin
      thr = $urandom_range(5, 90);
      for (int k = 0; k < 60; k++) begin
        x = inData;
        if ($urandom_range(0, 99) < thr) x = ~x;
        step(x, ($urandom_range(0, 29) == 0), ($urandom_range(0, 149) == 0));
      end
    end
    // Quiet tail: output must settle to the input level
    idle(60);
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d left want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
